// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
// Single-frame SPI master (mode 0). Each accepted request shifts out one
// 16-bit frame {wr, addr[6:0], data[7:0]}, MSB first, framed by an active-low
// chip select, followed by a guard gap with chip select high.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (legal 2..255)
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset (priority over start)
//   start  in   transaction request, accepted only in IDLE
//   wr     in   frame bit 15
//   addr   in   frame bits 14:8
//   data   in   frame bits 7:0
//   busy   out  high while a transaction is in progress
//   done   out  one-cycle completion pulse (coincides with return to IDLE)
//   nCS    out  chip select, active low
//   SCLK   out  serial clock, idle low
//   COPI   out  serial data out
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    GAP      = 3'd4
  } state_t;

  // Divider only needs to count 0..CLK_DIV-1 inside one phase.
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shreg_q, shreg_d;
  logic          gap_half_q, gap_half_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ncs_q, ncs_d;
  logic          sclk_q, sclk_d;
  logic          copi_q, copi_d;
  logic          phase_end;

  assign phase_end = (div_q == DIV_LAST);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= 4'd0;
      shreg_q    <= 16'd0;
      gap_half_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ncs_q      <= 1'b1;
      sclk_q     <= 1'b0;
      copi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      gap_half_q <= gap_half_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ncs_q      <= ncs_d;
      sclk_q     <= sclk_d;
      copi_q     <= copi_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that they land in flops together with the state they belong to.
  always_comb begin
    state_d    = state_q;
    div_d      = phase_end ? '0 : div_q + {{(DW-1){1'b0}}, 1'b1};
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    gap_half_d = gap_half_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ncs_d      = ncs_q;
    sclk_d     = sclk_q;
    copi_d     = copi_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (start) begin
          state_d    = SETUP;
          shreg_d    = {wr, addr, data};
          copi_d     = wr;
          ncs_d      = 1'b0;
          busy_d     = 1'b1;
          bit_d      = 4'd0;
          gap_half_d = 1'b0;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
        end
      end
      SHIFT_HI: begin
        // Falling edge: advance the shift register and present the next bit.
        // After the last bit this shifts in a zero, so COPI idles low in hold.
        if (phase_end) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[14:0], 1'b0};
          copi_d  = shreg_q[14];
        end
      end
      SHIFT_LO: begin
        if (phase_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = GAP;
            ncs_d   = 1'b1;
            copi_d  = 1'b0;
          end else begin
            state_d = SHIFT_HI;
            sclk_d  = 1'b1;
          end
        end
      end
      GAP: begin
        // Gap spans two divider periods, tracked by gap_half.
        if (phase_end) begin
          if (gap_half_q) begin
            state_d    = IDLE;
            gap_half_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            gap_half_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        div_d      = '0;
        bit_d      = 4'd0;
        shreg_d    = 16'd0;
        gap_half_d = 1'b0;
        busy_d     = 1'b0;
        ncs_d      = 1'b1;
        sclk_d     = 1'b0;
        copi_d     = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign nCS  = ncs_q;
  assign SCLK = sclk_q;
  assign COPI = copi_q;

endmodule
